mdu_iter: RTL and testbench

Iterative multiply/divide unit for the RV64M extension, sitting in the execute stage directly downstream of the operand-forwarding logic. It consumes the forwarded execute-stage operands, runs a radix-2 shift-add multiply or restoring divide over 32 or 64 cycles, and drives a `busy` stall toward the hazard unit. When the result is ready it raises a one-cycle `done` and holds the result for the execute/memory pipeline register.

---
 rtl/mdu_iter.sv | 165 ++++++++++++++++
 tb/tb_mdu_iter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Runs 64 iterations for 64-bit ops and 32 for W ops; divide-by-zero, overflow and illegal ops finish in one cycle.
module mdu_iter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateE;
  typedef enum logic [3:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
  } opE;

  stateE           state;
  logic [5:0]      cnt;
  logic [3:0]      opR;
  logic            isW, negRes;
  logic [XLEN-1:0] opA, opB, accHi, accLo;

  logic            inW, inMul, sgnA, sgnB, sa, sb, negFlag, divZero, ovf, illegal, special;
  logic [31:0]     negA32, negB32;
  logic [XLEN-1:0] absA, absB, specRes, loadLo;

  // Launch-side decode of the incoming operation
  always_comb begin
    inW     = op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    inMul   = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    sgnA    = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    sgnB    = op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    sa      = sgnA & (inW ? srca[31] : srca[XLEN-1]);
    sb      = sgnB & (inW ? srcb[31] : srcb[XLEN-1]);
    negA32  = -srca[31:0];
    negB32  = -srcb[31:0];
    absA    = inW ? {32'b0, (sa ? negA32 : srca[31:0])} : (sa ? -srca : srca);
    absB    = inW ? {32'b0, (sb ? negB32 : srcb[31:0])} : (sb ? -srcb : srcb);
    illegal = op > 4'd12;
    divZero = !inMul && !illegal && (inW ? (srcb[31:0] == '0) : (srcb == '0));
    ovf     = ((op == OP_DIV || op == OP_REM) && srca == {1'b1, {(XLEN-1){1'b0}}} && srcb == '1)
           || ((op == OP_DIVW || op == OP_REMW) && srca[31:0] == 32'h8000_0000 && srcb[31:0] == '1);
    special = illegal || divZero || ovf;
    negFlag = 1'b0;
    if (op inside {OP_MULH, OP_DIV, OP_DIVW}) negFlag = sa ^ sb;
    else if (op inside {OP_MULHSU, OP_REM, OP_REMW}) negFlag = sa;
    loadLo = inMul ? absB : (inW ? {absA[31:0], 32'b0} : absA);
    specRes = '0;
    if (divZero) begin
      case (op)
        OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW: specRes = '1;
        OP_REM, OP_REMU:                    specRes = srca;
        default:                            specRes = {{32{srca[31]}}, srca[31:0]};
      endcase
    end else if (ovf) begin
      case (op)
        OP_DIV:  specRes = srca;
        OP_DIVW: specRes = {{32{srca[31]}}, srca[31:0]};
        default: specRes = '0;
      endcase
    end
  end

  logic [XLEN:0]   mulSum, divShift;
  logic [XLEN-1:0] divSub, nextHi, nextLo, mulHiFix, qFix, rFix, finalRes;
  logic [31:0]     q32, r32;
  logic            divGe, opMul, last;

  // One iteration step plus the sign fixup applied on the final step
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opA} : '0);
    divShift = {accHi, accLo[XLEN-1]};
    divGe    = divShift >= {1'b0, opB};
    divSub   = divShift[XLEN-1:0] - opB;
    opMul    = opR inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    nextHi   = opMul ? mulSum[XLEN:1] : (divGe ? divSub : divShift[XLEN-1:0]);
    nextLo   = opMul ? {mulSum[0], accLo[XLEN-1:1]} : {accLo[XLEN-2:0], divGe};
    // High half of a 128-bit negation: invert, carry in only when the low half is zero
    mulHiFix = negRes ? (~nextHi + {{(XLEN-1){1'b0}}, (nextLo == '0)}) : nextHi;
    qFix     = negRes ? -nextLo : nextLo;
    rFix     = negRes ? -nextHi : nextHi;
    q32      = negRes ? -nextLo[31:0] : nextLo[31:0];
    r32      = negRes ? -nextHi[31:0] : nextHi[31:0];
    case (opR)
      OP_MUL:                        finalRes = nextLo;
      OP_MULH, OP_MULHSU, OP_MULHU:  finalRes = mulHiFix;
      OP_MULW:                       finalRes = {{32{nextLo[63]}}, nextLo[63:32]};
      OP_DIV, OP_DIVU:               finalRes = qFix;
      OP_REM, OP_REMU:               finalRes = rFix;
      OP_DIVW, OP_DIVUW:             finalRes = {{32{q32[31]}}, q32};
      OP_REMW, OP_REMUW:             finalRes = {{32{r32[31]}}, r32};
      default:                       finalRes = '0;
    endcase
    last = cnt == (isW ? 6'd31 : 6'd63);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      opR    <= '0;
      isW    <= 1'b0;
      negRes <= 1'b0;
      opA    <= '0;
      opB    <= '0;
      accHi  <= '0;
      accLo  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            opR    <= op;
            isW    <= inW;
            negRes <= negFlag;
            opA    <= absA;
            opB    <= absB;
            accHi  <= '0;
            accLo  <= loadLo;
            cnt    <= '0;
            if (special) begin
              result <= specRes;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            accHi <= nextHi;
            accLo <= nextLo;
            if (last) begin
              cnt    <= '0;
              result <= finalRes;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              cnt  <= cnt + 6'd1;
              busy <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed RV64M cases, flush/reset scenarios and random ops
// checked against an arithmetic reference model for both result value and done timing.
module tb_mdu_iter;

  localparam logic [3:0] MUL = 4'd0, MULH = 4'd1, MULHSU = 4'd2, MULHU = 4'd3,
                         DIV = 4'd4, DIVU = 4'd5, REM = 4'd6, REMU = 4'd7,
                         MULW = 4'd8, DIVW = 4'd9, DIVUW = 4'd10, REMW = 4'd11, REMUW = 4'd12;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [3:0]  op;
  logic [63:0] srca, srcb, result;
  logic        busy, done;

  typedef struct {
    logic [63:0] res;
    int unsigned cyc;
    string       name;
  } expT;

  expT         sbq[$];
  int unsigned cyc = 0;
  int unsigned nCmp = 0, nErr = 0;
  logic [63:0] lastExp = '0;

  mdu_iter #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  function automatic logic [63:0] refModel(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ua, ub, sa, sb, p;
    longint       la, lb;
    int           ia, ib;
    logic [31:0]  ua32, ub32;
    ua = {64'b0, a}; ub = {64'b0, b};
    sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b};
    la = a; lb = b; ia = a[31:0]; ib = b[31:0];
    ua32 = a[31:0]; ub32 = b[31:0];
    case (o)
      MUL:    begin p = ua * ub; return p[63:0]; end
      MULH:   begin p = sa * sb; return p[127:64]; end
      MULHSU: begin p = sa * ub; return p[127:64]; end
      MULHU:  begin p = ua * ub; return p[127:64]; end
      DIV:    if (b == 0) return '1; else if (a == MIN64 && b == '1) return a; else return la / lb;
      DIVU:   if (b == 0) return '1; else return a / b;
      REM:    if (b == 0) return a; else if (a == MIN64 && b == '1) return 0; else return la % lb;
      REMU:   if (b == 0) return a; else return a % b;
      MULW:   return sext32(ua32 * ub32);
      DIVW:   if (ib == 0) return '1; else if (ua32 == 32'h8000_0000 && ib == -1) return sext32(ua32);
              else return sext32(ia / ib);
      DIVUW:  if (ub32 == 0) return '1; else return sext32(ua32 / ub32);
      REMW:   if (ib == 0) return sext32(ua32); else if (ua32 == 32'h8000_0000 && ib == -1) return 0;
              else return sext32(ia % ib);
      REMUW:  if (ub32 == 0) return sext32(ua32); else return sext32(ua32 % ub32);
      default: return 0;
    endcase
  endfunction

  // Cycles from the start edge to the cycle in which done is seen
  function automatic int unsigned refLat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    bit isW, isDiv, zero, ovf;
    isW   = o >= 4'd8 && o <= 4'd12;
    isDiv = (o >= 4'd4 && o <= 4'd7) || (o >= 4'd9 && o <= 4'd12);
    zero  = isW ? (b[31:0] == 0) : (b == 0);
    ovf   = ((o == DIV || o == REM) && a == MIN64 && b == '1)
         || ((o == DIVW || o == REMW) && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
    if (o > 4'd12 || (isDiv && (zero || ovf))) return 1;
    return isW ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = 0;
      1: v = '1;
      2: v = MIN64;
      3: v = 64'h0000_0000_8000_0000;
      4: v = 64'($urandom_range(0, 20));
      5: v = sext32($urandom);
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Monitor: pops and checks whenever the DUT signals completion
  always @(negedge clk) begin
    if (!reset) begin
      if (busy && done) check("busy_and_done", 64'(busy & done), 64'd0);
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          expT e;
          e = sbq.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic launch(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input string nm);
    int unsigned lat;
    logic [63:0] r;
    @(negedge clk);
    r   = refModel(o, a, b);
    lat = refLat(o, a, b);
    sbq.push_back('{r, cyc + lat, nm});
    lastExp = r;
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_k1"}, 64'(busy), 64'(lat > 1));
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      check("done_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input string nm);
    launch(o, a, b, nm);
    waitIdle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; srca = '0; srcb = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    reset = 1'b0;

    issue(MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul_7_m3");
    issue(MULH,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mulh_7_m3");
    issue(MULHU,  '1, '1, "mulhu_ones");
    issue(MULHSU, '1, 64'd2, "mulhsu_m1_2");
    issue(DIV,    -64'sd7, 64'd2, "div_m7_2");
    issue(REM,    -64'sd7, 64'd2, "rem_m7_2");
    issue(DIVU,   64'd100, 64'd7, "divu_100_7");
    issue(REMUW,  64'h1_0000_0009, 64'd4, "remuw");
    issue(DIV,    64'd1234, 64'd0, "div_by0");
    issue(REM,    64'd1234, 64'd0, "rem_by0");
    issue(DIV,    MIN64, '1, "div_ovf");
    issue(DIVW,   64'h8000_0000, '1, "divw_ovf");
    issue(4'd14,  64'd5, 64'd6, "illegal");

    // Flush during a running divide: no done, result keeps previous value
    @(negedge clk);
    c = cyc;
    start = 1'b1; op = DIV; srca = -64'sd1000; srcb = 64'd3;
    @(negedge clk);
    start = 1'b0;
    while (cyc != c + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_result", result, lastExp);
    repeat (70) @(negedge clk);
    check("flush_result_later", result, lastExp);

    // start together with flush is not launched
    start = 1'b1; flush = 1'b1; op = DIV; srca = 64'd9; srcb = 64'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("startflush_busy", 64'(busy), 64'd0);
    check("startflush_done", 64'(done), 64'd0);
    repeat (4) @(negedge clk);

    // start during RUN is ignored
    launch(DIVU, 64'd100, 64'd7, "divu_ignore_start");
    repeat (5) @(negedge clk);
    start = 1'b1; op = DIV; srca = 64'd5; srcb = 64'd0;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    // Asynchronous reset mid-RUN
    launch(MUL, 64'd123456, 64'd654321, "mul_reset");
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_result", result, 64'd0);
    sbq.delete();
    lastExp = '0;
    @(negedge clk);
    reset = 1'b0;
    issue(MULW, 64'h7FFF_FFFF, 64'd2, "mulw_after_reset");

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  o;
      logic [63:0] a, b;
      o = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      issue(o, a, b, $sformatf("rand%0d_op%0d", i, o));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
